// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequencing controller for the WIDTH-bit counter datapath. A start pulse
// captures the run configuration into shadow registers, loads the start
// value and enters RUN. Each tick moves the count one step toward the
// captured terminal value. On the terminal tick the block either reloads
// (continuous mode) or parks in DONE (one-shot mode). A one-cycle done
// pulse marks every terminal event.
//
// Optional feature: define COUNTER_SEQ_CTRL_PRESCALE_EN to compile in a
// tick prescaler that advances the count once every PRESCALE RUN cycles.
// Without the macro every RUN edge is a tick and PRESCALE is ignored.
//
// Parameters:
//   WIDTH     counter / value width in bits
//   PRESCALE  cycles per tick when the prescaler is compiled in (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        capture config, load count, enter RUN (restarts any state)
//   stop         abort to IDLE and clear the count
//   pause        level; freezes counting while high in RUN/HOLD
//   load_val     start/reload value, sampled on start
//   term_val     terminal value, sampled on start
//   dir          0 = count up, 1 = count down, sampled on start
//   auto_reload  1 = continuous, 0 = one-shot, sampled on start
//   count        current count (registered)
//   state        IDLE=00, RUN=01, HOLD=10, DONE=11 (registered)
//   busy         high in RUN or HOLD (registered)
//   done         one-cycle pulse after each terminal tick (registered)
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             dir,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  // Configuration captured at start; the live inputs are ignored mid-run.
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] term_q;
  logic             dir_q;
  logic             reload_q;

  // Qualifies a RUN edge as one that advances the count.
  logic tick;

  // Counting only happens on RUN edges without pause; this is the enable the
  // prescaler shares with the main sequencer.
  logic run_active;
  assign run_active = (state == ST_RUN) && !pause;

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [PRESC_W-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  // Prescaler: counts 0..PRESCALE-1 while actively running and wraps on the
  // tick, so a reload naturally restarts it from zero. It holds in HOLD,
  // DONE and IDLE, and is cleared by reset, stop and start.
  always_ff @(posedge clk) begin
    if (reset || stop || start) begin
      presc <= '0;
    end else if (run_active) begin
      if (tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PRESC_ONE;
      end
    end
  end

`else

  assign tick = 1'b1;

  // PRESCALE has no role without the prescaler; fold it into a sink so the
  // parameter stays part of the interface.
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;

`endif

  // Shadow configuration registers, written only by a start that is not
  // overridden by reset or stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q   <= ZERO;
      term_q   <= ZERO;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
    end else if (!stop && start) begin
      load_q   <= load_val;
      term_q   <= term_val;
      dir_q    <= dir;
      reload_q <= auto_reload;
    end
  end

  // Main sequencer. Priority is reset > stop > start > pause > tick. done is
  // a single-cycle pulse, so it defaults low every edge and is only raised by
  // a terminal tick that is not pre-empted by stop or start.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      count <= ZERO;
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else if (stop) begin
      count <= ZERO;
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else if (start) begin
      count <= load_val;
      state <= ST_RUN;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state <= ST_HOLD;
          end else if (tick) begin
            if (count == term_q) begin
              done <= 1'b1;
              if (reload_q) begin
                count <= load_q;
              end else begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end
            end else if (dir_q) begin
              count <= count - ONE;
            end else begin
              count <= count + ONE;
            end
          end
        end
        // Leaving HOLD costs one edge; ticking resumes on the edge after.
        ST_HOLD: begin
          if (!pause) begin
            state <= ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
